// File: rtl/key_pkg.sv
// Shared types, board timing defaults and counter sizing for the key conditioner.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      PRESSED    = 2'd2,
      DB_RELEASE = 2'd3
   } key_state_e;

   // 50 MHz board: 10 ms debounce, 1 s long press, 200 ms repeat
   localparam int unsigned CLK_HZ                = 50_000_000;
   localparam int unsigned DEF_DEBOUNCE_CYCLES   = 500_000;
   localparam int unsigned DEF_LONG_CYCLES       = 50_000_000;
   localparam int unsigned DEF_REPEAT_CYCLES     = 10_000_000;

   function automatic int cnt_width(input int unsigned a, input int unsigned b,
                                    input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, symmetric debounce FSM, long-press and repeat timing.
//
// state      | meaning
// IDLE       | key released and accepted as released
// DB_PRESS   | key seen pressed, counting stable cycles before accepting
// PRESSED    | press accepted; hold timer runs long/repeat pulses
// DB_RELEASE | key seen released, counting stable cycles; hold timing frozen
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int unsigned KEY_ACTIVE_HIGH = 1,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int unsigned REPEAT_EN       = 1,
   parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
   localparam logic          ACT_LVL   = (KEY_ACTIVE_HIGH != 0);
   localparam logic          REL_LVL   = ~ACT_LVL;

   logic          sync1_q, sync2_q;
   logic          kp;
   key_state_e    state_q, state_d;
   logic [CW-1:0] db_cnt_q, db_cnt_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;
   logic          long_done_q, long_done_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          rel_q, rel_d;
   logic          long_q, long_d;
   logic          rep_q, rep_d;

   assign kp = ~(sync2_q ^ ACT_LVL);

   always_comb begin
      state_d     = state_q;
      db_cnt_d    = db_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      long_done_d = long_done_q;
      level_d     = level_q;
      press_d     = 1'b0;
      rel_d       = 1'b0;
      long_d      = 1'b0;
      rep_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (kp) begin
               state_d  = DB_PRESS;
               db_cnt_d = '0;
            end
         end
         DB_PRESS: begin
            if (!kp) begin
               state_d = IDLE;
            end else if (db_cnt_q == DB_LAST) begin
               state_d     = PRESSED;
               level_d     = 1'b1;
               press_d     = 1'b1;
               hold_cnt_d  = '0;
               long_done_d = 1'b0;
            end else begin
               db_cnt_d = db_cnt_q + CW'(1);
            end
         end
         PRESSED: begin
            if (!kp) begin
               state_d  = DB_RELEASE;
               db_cnt_d = '0;
            end else if (!long_done_q) begin
               if (hold_cnt_q == LONG_LAST) begin
                  long_d      = 1'b1;
                  long_done_d = 1'b1;
                  hold_cnt_d  = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + CW'(1);
               end
            end else if (REPEAT_EN != 0) begin
               if (hold_cnt_q == REP_LAST) begin
                  rep_d      = 1'b1;
                  hold_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + CW'(1);
               end
            end
         end
         DB_RELEASE: begin
            // a bounce back to pressed resumes the frozen hold timing, no new press
            if (kp) begin
               state_d = PRESSED;
            end else if (db_cnt_q == DB_LAST) begin
               state_d = IDLE;
               level_d = 1'b0;
               rel_d   = 1'b1;
            end else begin
               db_cnt_d = db_cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q     <= REL_LVL;
         sync2_q     <= REL_LVL;
         state_q     <= IDLE;
         db_cnt_q    <= '0;
         hold_cnt_q  <= '0;
         long_done_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         rel_q       <= 1'b0;
         long_q      <= 1'b0;
         rep_q       <= 1'b0;
      end else begin
         sync1_q     <= key_in;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         db_cnt_q    <= db_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         long_done_q <= long_done_d;
         level_q     <= level_d;
         press_q     <= press_d;
         rel_q       <= rel_d;
         long_q      <= long_d;
         rep_q       <= rep_d;
      end
   end

   assign key_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = rel_q;
   assign long_pulse    = long_q;
   assign repeat_pulse  = rep_q;

endmodule

// File: rtl/key_debounce_multi.sv
// N independent key channels plus a registered lowest-index "any key pressed" event.
module key_debounce_multi
   import key_pkg::*;
#(
   parameter int unsigned N_KEYS          = 4,
   parameter int unsigned KEY_ACTIVE_HIGH = 1,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int unsigned REPEAT_EN       = 1,
   parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
   localparam int IDXW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] long_pulse,
   output logic [N_KEYS-1:0] repeat_pulse,
   output logic              press_any,
   output logic [IDXW-1:0]   press_idx
);

   logic            press_any_q, press_any_d;
   logic [IDXW-1:0] press_idx_q, press_idx_d;

   for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
      key_debounce_ch #(
         .KEY_ACTIVE_HIGH (KEY_ACTIVE_HIGH),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES),
         .REPEAT_EN       (REPEAT_EN),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .key_in        (key_in[g]),
         .key_level     (key_level[g]),
         .press_pulse   (press_pulse[g]),
         .release_pulse (release_pulse[g]),
         .long_pulse    (long_pulse[g]),
         .repeat_pulse  (repeat_pulse[g])
      );
   end

   // scan from the top so the lowest set index wins
   always_comb begin
      press_any_d = |press_pulse;
      press_idx_d = '0;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (press_pulse[i]) press_idx_d = IDXW'(i);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         press_any_q <= 1'b0;
         press_idx_q <= '0;
      end else begin
         press_any_q <= press_any_d;
         press_idx_q <= press_idx_d;
      end
   end

   assign press_any = press_any_q;
   assign press_idx = press_idx_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed scenarios at fixed edge numbers, then random key activity against a timing model.
module tb_key_debounce_multi;

   localparam int NK = 2;
   localparam int DB = 4;
   localparam int LG = 20;
   localparam int RP = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NK-1:0] key_in = '0;
   logic [NK-1:0] key_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
   logic          press_any;
   logic [0:0]    press_idx;

   int n_cmp = 0;
   int n_err = 0;

   key_debounce_multi #(
      .N_KEYS(NK), .KEY_ACTIVE_HIGH(1), .DEBOUNCE_CYCLES(DB),
      .LONG_CYCLES(LG), .REPEAT_EN(1), .REPEAT_CYCLES(RP)
   ) dut (
      .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .long_pulse(long_pulse), .repeat_pulse(repeat_pulse),
      .press_any(press_any), .press_idx(press_idx)
   );

   always #5 clk = ~clk;

   // Model: a key level flips after DB+1 consecutive edges of the opposite
   // (2-edge delayed) input; long/repeat fire on absolute counts of pressed time.
   logic [NK-1:0] m_s1, m_s2, m_kp, m_level, m_press, m_rel, m_long, m_rep;
   logic          m_any;
   logic [0:0]    m_idx;
   int            m_run[NK];
   int            m_act[NK];

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_level = '0;
      m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
      m_any = 1'b0; m_idx = '0;
      for (int i = 0; i < NK; i++) begin m_run[i] = 0; m_act[i] = 0; end
   endtask

   task automatic model_step();
      m_any = |m_press;
      m_idx = '0;
      for (int i = NK - 1; i >= 0; i--) if (m_press[i]) m_idx = 1'(i);
      m_kp = m_s2; m_s2 = m_s1; m_s1 = key_in;
      m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
      for (int i = 0; i < NK; i++) begin
         if (!m_level[i]) begin
            if (m_kp[i]) begin
               m_run[i]++;
               if (m_run[i] == DB + 1) begin
                  m_level[i] = 1'b1; m_press[i] = 1'b1; m_run[i] = 0; m_act[i] = 0;
               end
            end else m_run[i] = 0;
         end else if (!m_kp[i]) begin
            m_run[i]++;
            if (m_run[i] == DB + 1) begin
               m_level[i] = 1'b0; m_rel[i] = 1'b1; m_run[i] = 0;
            end
         end else if (m_run[i] > 0) begin
            m_run[i] = 0;
         end else begin
            m_act[i]++;
            if (m_act[i] == LG) m_long[i] = 1'b1;
            else if (m_act[i] > LG && (m_act[i] - LG) % RP == 0) m_rep[i] = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      key_in = '0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({key_level, press_pulse, release_pulse, long_pulse, repeat_pulse, press_any, press_idx} !== '0)
         begin n_err++; $display("FAIL reset_outputs: got %b expected all 0",
            {key_level, press_pulse, release_pulse, long_pulse, repeat_pulse, press_any, press_idx}); end
      rst = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if ({key_level, press_pulse, press_any} !== '0)
            begin n_err++; $display("FAIL reset_idle edge %0d: got %b expected 0", k, {key_level, press_pulse, press_any}); end
      end
   endtask

   task automatic test_clean_press();
      logic [NK-1:0] ep, el;
      key_in = '0;
      do_reset();
      key_in = 2'b01;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); @(negedge clk);
         ep = (k == 7) ? 2'b01 : 2'b00;
         el = (k >= 7) ? 2'b01 : 2'b00;
         n_cmp++;
         if (press_pulse !== ep) begin n_err++; $display("FAIL clean_press edge %0d: got %b expected %b", k, press_pulse, ep); end
         n_cmp++;
         if (key_level !== el) begin n_err++; $display("FAIL clean_level edge %0d: got %b expected %b", k, key_level, el); end
         n_cmp++;
         if (press_any !== (k == 8)) begin n_err++; $display("FAIL clean_any edge %0d: got %b expected %b", k, press_any, (k == 8)); end
         if (k == 8) begin
            n_cmp++;
            if (press_idx !== 1'b0) begin n_err++; $display("FAIL clean_idx: got %0d expected 0", press_idx); end
         end
      end
      key_in = '0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_bounce();
      key_in = '0;
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         key_in[0] = (k <= 8) && (((k - 1) / 2) % 2 == 0);
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if (press_pulse !== 2'b00 || key_level !== 2'b00)
            begin n_err++; $display("FAIL bounce edge %0d: got press %b level %b expected 00 00", k, press_pulse, key_level); end
      end
   endtask

   task automatic test_long_repeat();
      logic [NK-1:0] ep, elg, erp;
      key_in = '0;
      do_reset();
      key_in = 2'b10;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); @(negedge clk);
         ep  = (k == 7)  ? 2'b10 : 2'b00;
         elg = (k == 27) ? 2'b10 : 2'b00;
         erp = (k == 35 || k == 43 || k == 51 || k == 59) ? 2'b10 : 2'b00;
         n_cmp++;
         if (press_pulse !== ep) begin n_err++; $display("FAIL lr_press edge %0d: got %b expected %b", k, press_pulse, ep); end
         n_cmp++;
         if (long_pulse !== elg) begin n_err++; $display("FAIL lr_long edge %0d: got %b expected %b", k, long_pulse, elg); end
         n_cmp++;
         if (repeat_pulse !== erp) begin n_err++; $display("FAIL lr_repeat edge %0d: got %b expected %b", k, repeat_pulse, erp); end
      end
      key_in = '0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_release_glitch();
      logic [NK-1:0] ep, el, elg, er;
      key_in = '0;
      do_reset();
      for (int k = 1; k <= 42; k++) begin
         key_in[0] = !(k == 11 || k == 12) && (k < 33);
         @(posedge clk); @(negedge clk);
         ep  = (k == 7)  ? 2'b01 : 2'b00;
         elg = (k == 30) ? 2'b01 : 2'b00;
         er  = (k == 39) ? 2'b01 : 2'b00;
         el  = (k >= 7 && k < 39) ? 2'b01 : 2'b00;
         n_cmp++;
         if (press_pulse !== ep) begin n_err++; $display("FAIL glitch_press edge %0d: got %b expected %b", k, press_pulse, ep); end
         n_cmp++;
         if (long_pulse !== elg) begin n_err++; $display("FAIL glitch_long edge %0d: got %b expected %b", k, long_pulse, elg); end
         n_cmp++;
         if (release_pulse !== er) begin n_err++; $display("FAIL glitch_release edge %0d: got %b expected %b", k, release_pulse, er); end
         n_cmp++;
         if (key_level !== el || repeat_pulse !== 2'b00)
            begin n_err++; $display("FAIL glitch_level edge %0d: got level %b rep %b expected %b 00", k, key_level, repeat_pulse, el); end
      end
   endtask

   task automatic test_simultaneous();
      logic [NK-1:0] ep;
      key_in = '0;
      do_reset();
      key_in = 2'b11;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); @(negedge clk);
         ep = (k == 7) ? 2'b11 : 2'b00;
         n_cmp++;
         if (press_pulse !== ep) begin n_err++; $display("FAIL simul_press edge %0d: got %b expected %b", k, press_pulse, ep); end
         n_cmp++;
         if (press_any !== (k == 8) || press_idx !== 1'b0)
            begin n_err++; $display("FAIL simul_any edge %0d: got any %b idx %0d expected %b 0", k, press_any, press_idx, (k == 8)); end
      end
      key_in = '0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset_mid_hold();
      logic [NK-1:0] ep, el;
      key_in = '0;
      do_reset();
      key_in = 2'b01;
      repeat (10) begin @(posedge clk); @(negedge clk); end
      n_cmp++;
      if (key_level !== 2'b01) begin n_err++; $display("FAIL midrst_held: got %b expected 01", key_level); end
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({key_level, press_pulse, release_pulse, long_pulse, repeat_pulse, press_any, press_idx} !== '0)
         begin n_err++; $display("FAIL midrst_async: got %b expected all 0",
            {key_level, press_pulse, release_pulse, long_pulse, repeat_pulse, press_any, press_idx}); end
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); @(negedge clk);
         ep = (k == 7) ? 2'b01 : 2'b00;
         el = (k >= 7) ? 2'b01 : 2'b00;
         n_cmp++;
         if (press_pulse !== ep || release_pulse !== 2'b00)
            begin n_err++; $display("FAIL midrst_repress edge %0d: got press %b rel %b expected %b 00", k, press_pulse, release_pulse, ep); end
         n_cmp++;
         if (key_level !== el) begin n_err++; $display("FAIL midrst_level edge %0d: got %b expected %b", k, key_level, el); end
      end
      key_in = '0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_random();
      int hold_left[NK];
      key_in = '0;
      do_reset();
      model_reset();
      for (int i = 0; i < NK; i++) hold_left[i] = $urandom_range(1, 30);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < NK; i++) begin
            if (hold_left[i] == 0) begin
               key_in[i] = ~key_in[i];
               hold_left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 45);
            end else hold_left[i]--;
         end
         @(posedge clk);
         model_step();
         @(negedge clk);
         n_cmp++;
         if (key_level !== m_level) begin n_err++; $display("FAIL rnd_level cyc %0d: got %b expected %b", cyc, key_level, m_level); end
         n_cmp++;
         if (press_pulse !== m_press) begin n_err++; $display("FAIL rnd_press cyc %0d: got %b expected %b", cyc, press_pulse, m_press); end
         n_cmp++;
         if (release_pulse !== m_rel) begin n_err++; $display("FAIL rnd_release cyc %0d: got %b expected %b", cyc, release_pulse, m_rel); end
         n_cmp++;
         if (long_pulse !== m_long) begin n_err++; $display("FAIL rnd_long cyc %0d: got %b expected %b", cyc, long_pulse, m_long); end
         n_cmp++;
         if (repeat_pulse !== m_rep) begin n_err++; $display("FAIL rnd_repeat cyc %0d: got %b expected %b", cyc, repeat_pulse, m_rep); end
         n_cmp++;
         if (press_any !== m_any || press_idx !== m_idx)
            begin n_err++; $display("FAIL rnd_any cyc %0d: got %b/%0d expected %b/%0d", cyc, press_any, press_idx, m_any, m_idx); end
         if (cyc == 1500) begin
            rst = 1'b0;
            model_reset();
            @(negedge clk);
            n_cmp++;
            if ({key_level, press_pulse, release_pulse, press_any} !== '0)
               begin n_err++; $display("FAIL rnd_reset: got %b expected 0", {key_level, press_pulse, release_pulse, press_any}); end
            rst = 1'b1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_repeat();
      test_release_glitch();
      test_simultaneous();
      test_reset_mid_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
Multi-channel push-button conditioner and the parametrised successor of the single-key debouncer.
- Per channel: input synchronisation, symmetric press/release debounce and a stable key level.
- Per channel pulses: press, release, long-press and auto-repeat, each one cycle wide.
- A priority-encoded "any key pressed" event for the front-panel and board-control logic.

Parameters:
N_KEYS, 4, number of independent key channels (1..16)
KEY_ACTIVE_HIGH, 1, 1: key_in=1 means pressed; 0: key_in=0 means pressed
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a press or a release (>=2)
LONG_CYCLES, 50000000, cycles held after the press is accepted before long_pulse fires (>=1)
REPEAT_EN, 1, 1 enables auto-repeat after long press
REPEAT_CYCLES, 10000000, auto-repeat period (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted at 0)
key_in  in  N_KEYS  raw asynchronous key pins
key_level  out  N_KEYS  debounced level, 1 = pressed
press_pulse  out  N_KEYS  1-cycle pulse when a press is accepted
release_pulse  out  N_KEYS  1-cycle pulse when a release is accepted
long_pulse  out  N_KEYS  1-cycle pulse at the long-press threshold
repeat_pulse  out  N_KEYS  1-cycle pulse every REPEAT_CYCLES after long press
press_any  out  1  1-cycle pulse if any press_pulse bit is set
press_idx  out  $clog2(N_KEYS) (min 1)  lowest index with press_pulse set; valid with press_any

Behaviour:
- Reset:
  - All outputs are 0. All channels are in IDLE with counters at 0.
  - The synchroniser flops reset to the released level (KEY_ACTIVE_HIGH ? 0 : 1).
- Input conditioning:
  - 2-FF synchroniser per bit.
  - kp = sync_out XNOR KEY_ACTIVE_HIGH, so kp=1 always means pressed.
- Per-channel FSM, with db_cnt and hold_cnt sized $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES)+1):
  - IDLE: kp=1 -> DB_PRESS, db_cnt=0.
  - DB_PRESS:
    - kp=0 -> IDLE (bounce rejected, no pulse).
    - Else if db_cnt==DEBOUNCE_CYCLES-1 -> PRESSED: key_level=1, press_pulse=1 for one cycle, hold_cnt=0, long_done=0.
    - Else db_cnt++.
  - PRESSED:
    - kp=0 -> DB_RELEASE, db_cnt=0.
    - Else, while long_done=0: hold_cnt++. When hold_cnt==LONG_CYCLES-1: long_pulse=1, long_done=1, hold_cnt=0.
    - Else, if long_done=1 and REPEAT_EN: hold_cnt++. When hold_cnt==REPEAT_CYCLES-1: repeat_pulse=1, hold_cnt=0.
    - Else, if long_done=1 and REPEAT_EN=0: hold_cnt holds.
  - DB_RELEASE:
    - kp=1 -> PRESSED. No new press_pulse; hold_cnt and long_done are kept, so the long/repeat timing is frozen for the bounce duration.
    - Else if db_cnt==DEBOUNCE_CYCLES-1 -> IDLE: key_level=0, release_pulse=1 for one cycle.
    - Else db_cnt++.
    - No long or repeat pulses are issued in DB_RELEASE.
- Latency: press_pulse is registered on the (DEBOUNCE_CYCLES+3)-th rising clk edge after key_in settles pressed (2 sync + 1 entry + DEBOUNCE_CYCLES). Release is symmetric.
- key_level changes in the same cycle as press_pulse / release_pulse.
- long_pulse occurs LONG_CYCLES cycles after press_pulse. The first repeat_pulse occurs REPEAT_CYCLES cycles after long_pulse, periodic thereafter.
- All outputs are registered and every pulse is exactly one cycle wide. At most one of press/release/long/repeat fires per channel per cycle.
- press_any / press_idx:
  - Registered one cycle after the press_pulse vector.
  - With simultaneous presses, the lowest index wins; the others are visible only on press_pulse.
  - press_idx=0 when press_any=0.
- Reset mid-operation: an asynchronous return to the reset state. No release_pulse is emitted for keys held at reset. A key still held after reset deasserts is debounced as a fresh press.
- Channels are fully independent.

Decomposition:
- Package key_pkg:
  - channel state enum {IDLE, DB_PRESS, PRESSED, DB_RELEASE}, 2 bits.
  - Counter-width helper function.
  - Default timing constants for the 50 MHz board (10 ms debounce, 1 s long, 200 ms repeat).
- Sub-module key_debounce_ch: synchroniser, FSM and counters for one channel.
- Top: a generate loop of N_KEYS instances plus the priority encoder and the press_any register.

Test Plan (N_KEYS=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, REPEAT_EN=1, KEY_ACTIVE_HIGH=1):
1. Clean press: key_in[0]=1 from cycle 0, held -> press_pulse[0] on edge 7 only; key_level[0]=1 from edge 7; press_any on edge 8 with press_idx=0.
2. Bounce: key_in[0] toggles 1,0,1,0 each 2 cycles, then stays 0 -> no press_pulse, key_level[0] stays 0.
3. Long and repeat: hold key_in[1]=1 for 60 cycles -> press_pulse[1] at edge 7; long_pulse[1] at edge 27; repeat_pulse[1] at edges 35, 43, 51, 59.
4. Release glitch: while pressed, drop key_in[0] for 2 cycles, then restore -> no release_pulse and no second press_pulse; long_pulse is delayed by the frozen span. Full release -> release_pulse[0] 7 edges after key_in falls.
5. Simultaneous press: both keys rise in the same cycle -> press_pulse=2'b11 at edge 7; press_any=1 with press_idx=0 at edge 8.
6. Reset mid-hold: assert rst=0 while key_level[0]=1 -> all outputs 0 immediately with no release_pulse; deassert with the key still high -> a fresh press_pulse 7 edges later.
